pc_seq_reg: RTL and testbench

PC_SEQ_REG -- requirements
Module: pc_seq_reg

---
 rtl/pc_seq_reg.sv | 114 +++++++++++
 tb/tb_pc_seq_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_reg.sv
// pc_seq_reg: sequencing register with load/inc/dec/signed-add and optional call/ret return stack.
// Define PC_SEQ_STACK_EN to build the return stack; without it call/ret only flag stk_err.
module pc_seq_reg #(
    parameter int          WIDTH = 16,
    parameter logic [63:0] STEP  = 64'd1,
    parameter int          SAT   = 0,
    parameter int          DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             add,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             ovf,
    output logic             conflict,
    output logic             stk_err,
    output logic             stk_full,
    output logic             stk_empty
);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    logic [WIDTH-1:0] q_q, q_d, top, inc_r, dec_r, add_r;
    logic [WIDTH:0]   inc_s, dec_s;
    logic [WIDTH+1:0] add_s;
    logic [2:0]       n;
    logic             one, add_o, ovf_q, ovf_d, conf_q, err_q, err_d, st_full, st_empty;

    assign n = 3'(ld) + 3'(inc) + 3'(dec) + 3'(add) + 3'(call) + 3'(ret);
    assign one = n == 3'd1;
    // Carry/borrow live in the extra top bits; add sign-extends D by two bits
    assign inc_s = {1'b0, q_q} + STEP_W;
    assign dec_s = {1'b0, q_q} - STEP_W;
    assign add_s = {2'b00, q_q} + {{2{D[WIDTH-1]}}, D};
    assign add_o = add_s[WIDTH+1] | add_s[WIDTH];
    assign inc_r = (inc_s[WIDTH] && SAT != 0) ? '1 : inc_s[WIDTH-1:0];
    assign dec_r = (dec_s[WIDTH] && SAT != 0) ? '0 : dec_s[WIDTH-1:0];
    assign add_r = (add_o && SAT != 0) ? (add_s[WIDTH+1] ? '0 : '1) : add_s[WIDTH-1:0];

    always_comb begin
        q_d = q_q;
        ovf_d = 1'b0;
        err_d = 1'b0;
        if (one) begin
            if (ld) q_d = D;
            if (inc) {ovf_d, q_d} = {inc_s[WIDTH], inc_r};
            if (dec) {ovf_d, q_d} = {dec_s[WIDTH], dec_r};
            if (add) {ovf_d, q_d} = {add_o, add_r};
            if (call) {err_d, q_d} = {st_full, st_full ? q_q : D};
            if (ret) {err_d, q_d} = {st_empty, st_empty ? q_q : top};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
            ovf_q <= 1'b0;
            conf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            q_q <= q_d;
            ovf_q <= ovf_d;
            conf_q <= n > 3'd1;
            err_q <= err_d;
        end
    end

`ifdef PC_SEQ_STACK_EN
    localparam int OW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] stk_q [2**OW];
    logic [OW-1:0]    occ_q, occ_d;
    logic             full_q, empty_q, push, pop;

    assign push = one && call && !full_q;
    assign pop = one && ret && !empty_q;
    assign occ_d = push ? occ_q + OW'(1) : pop ? occ_q - OW'(1) : occ_q;
    assign top = stk_q[occ_q - OW'(1)];
    assign st_full = full_q;
    assign st_empty = empty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            occ_q <= occ_d;
            full_q <= occ_d == OW'(DEPTH);
            empty_q <= occ_d == '0;
        end
    end

    // Entry contents are don't-care after reset, so no reset on the storage
    always_ff @(posedge clk) begin
        if (push) stk_q[occ_q] <= inc_r;
    end
`else
    assign st_full = DEPTH >= 1;
    assign st_empty = 1'b1;
    assign top = '0;
`endif

    assign Q = q_q;
    assign zero = q_q == '0;
    assign ovf = ovf_q;
    assign conflict = conf_q;
    assign stk_err = err_q;
    assign stk_full = st_full;
    assign stk_empty = st_empty;
endmodule

// File: tb/tb_pc_seq_reg.sv
// tb_pc_seq_reg: two configurations (STEP=1 wrap, STEP=4 saturate) driven in lockstep against an arithmetic model.
module tb_pc_seq_reg;
    localparam logic [5:0] LD = 6'b100000, INC = 6'b010000, DEC = 6'b001000;
    localparam logic [5:0] ADD = 6'b000100, CALL = 6'b000010, RET = 6'b000001;
    localparam int MDEPTH = 2;
`ifdef PC_SEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0;
    logic ld = 0, inc = 0, dec = 0, add = 0, call = 0, ret = 0;
    logic [15:0] D = '0;
    logic [15:0] q_o [2];
    logic z_o [2], ovf_o [2], cf_o [2], er_o [2], fu_o [2], em_o [2];

    int total = 0, bad = 0;
    bit chk_on = 0;
    int mq [2] = '{0, 0};
    bit movf [2] = '{0, 0}, mconf [2] = '{0, 0}, merr [2] = '{0, 0};
    int sv [2][MDEPTH];
    int so [2] = '{0, 0};

    always #5 clk = ~clk;

    pc_seq_reg #(.WIDTH(16), .STEP(64'd1), .SAT(0), .DEPTH(MDEPTH)) u0 (
        .clk(clk), .reset(reset), .ld(ld), .inc(inc), .dec(dec), .add(add), .call(call), .ret(ret),
        .D(D), .Q(q_o[0]), .zero(z_o[0]), .ovf(ovf_o[0]), .conflict(cf_o[0]), .stk_err(er_o[0]),
        .stk_full(fu_o[0]), .stk_empty(em_o[0]));
    pc_seq_reg #(.WIDTH(16), .STEP(64'd4), .SAT(1), .DEPTH(MDEPTH)) u1 (
        .clk(clk), .reset(reset), .ld(ld), .inc(inc), .dec(dec), .add(add), .call(call), .ret(ret),
        .D(D), .Q(q_o[1]), .zero(z_o[1]), .ovf(ovf_o[1]), .conflict(cf_o[1]), .stk_err(er_o[1]),
        .stk_full(fu_o[1]), .stk_empty(em_o[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            mq[k] = 0; movf[k] = 0; mconf[k] = 0; merr[k] = 0; so[k] = 0;
        end
    endtask

    // Result of one clock edge, straight from the arithmetic rules
    task automatic mstep(input int k);
        int step = (k == 1) ? 4 : 1;
        bit sat = (k == 1);
        int n = ld + inc + dec + add + call + ret;
        longint r = mq[k];
        movf[k] = 0; merr[k] = 0; mconf[k] = n > 1;
        if (n == 1) begin
            if (ld) mq[k] = D;
            else if (inc || dec || add) begin
                r = inc ? r + step : dec ? r - step : r + longint'($signed(D));
                if (r < 0 || r > 65535) begin
                    movf[k] = 1;
                    mq[k] = sat ? (r < 0 ? 0 : 65535) : int'(r & 65535);
                end else mq[k] = int'(r);
            end else if (call) begin
                if (!STK || so[k] == MDEPTH) merr[k] = 1;
                else begin
                    r = mq[k] + step;
                    sv[k][so[k]] = sat ? (r > 65535 ? 65535 : int'(r)) : int'(r & 65535);
                    so[k]++;
                    mq[k] = D;
                end
            end else begin
                if (!STK || so[k] == 0) merr[k] = 1;
                else begin
                    so[k]--;
                    mq[k] = sv[k][so[k]];
                end
            end
        end
    endtask

    task automatic op(input logic [5:0] s, input logic [15:0] d, input bit rp = 0);
        {ld, inc, dec, add, call, ret} = s;
        D = d;
        if (rp) begin
            #2 reset = 1'b1;
            mreset();
            #2 reset = 1'b0;
        end
        @(posedge clk);
        mstep(0);
        mstep(1);
        @(negedge clk);
        {ld, inc, dec, add, call, ret} = 6'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d Q", k), q_o[k], mq[k]);
                chk($sformatf("u%0d zero", k), z_o[k], mq[k] == 0);
                chk($sformatf("u%0d ovf", k), ovf_o[k], movf[k]);
                chk($sformatf("u%0d conflict", k), cf_o[k], mconf[k]);
                chk($sformatf("u%0d stk_err", k), er_o[k], merr[k]);
                chk($sformatf("u%0d stk_full", k), fu_o[k], STK ? so[k] == MDEPTH : 1'b1);
                chk($sformatf("u%0d stk_empty", k), em_o[k], STK ? so[k] == 0 : 1'b1);
            end
        end
    end

    initial begin
        logic [15:0] ev [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFE, 16'h8000, 16'h7FFF};
        #1 reset = 1'b1;
        mreset();
        #2;
        chk("reset Q", q_o[0], 16'h0);
        chk("reset empty", em_o[0], 1'b1);
        chk("reset pulses", {ovf_o[0], cf_o[0], er_o[0]}, 3'b0);
`ifdef PC_SEQ_STACK_EN
        chk("reset full", fu_o[0], 1'b0);
`else
        chk("reset full", fu_o[0], 1'b1);
`endif
        chk_on = 1;
        @(negedge clk);
        reset = 1'b0;
        op(LD, 16'h1234);
        chk("first op after reset", q_o[1], 16'h1234);
        op(LD, 16'hFFFF);
        op(INC, 16'h0);
        chk("wrap inc Q", q_o[0], 16'h0000);
        chk("wrap inc ovf", ovf_o[0], 1'b1);
        chk("wrap inc zero", z_o[0], 1'b1);
        chk("sat inc Q", q_o[1], 16'hFFFF);
        op(LD, 16'd3);
        op(DEC, 16'h0);
        chk("sat dec Q", q_o[1], 16'h0);
        chk("sat dec ovf", ovf_o[1], 1'b1);
        chk("wrap dec Q", q_o[0], 16'd2);
        op(ADD, 16'hFFFE);
        chk("sat add Q", q_o[1], 16'h0);
        chk("sat add ovf", ovf_o[1], 1'b1);
        chk("wrap add ovf", ovf_o[0], 1'b0);
        op(LD, 16'd5);
        op(LD | INC, 16'h0);
        chk("conflict Q", q_o[0], 16'd5);
        chk("conflict pulse", cf_o[0], 1'b1);
        op(6'b0, 16'h0);
        chk("conflict clears", cf_o[0], 1'b0);
`ifdef PC_SEQ_STACK_EN
        op(LD, 16'd10);
        op(CALL, 16'd100);
        chk("call1 Q", q_o[0], 16'd100);
        op(CALL, 16'd200);
        chk("call2 Q", q_o[0], 16'd200);
        chk("call2 full", fu_o[0], 1'b1);
        op(CALL, 16'd300);
        chk("call full Q", q_o[0], 16'd200);
        chk("call full err", er_o[0], 1'b1);
        op(RET, 16'h0);
        chk("ret1 Q", q_o[0], 16'd101);
        chk("ret1 Q step4", q_o[1], 16'd104);
        op(RET, 16'h0);
        chk("ret2 Q", q_o[0], 16'd11);
        chk("ret2 empty", em_o[0], 1'b1);
        op(RET, 16'h0);
        chk("ret empty err", er_o[0], 1'b1);
        chk("ret empty Q", q_o[0], 16'd11);
`else
        op(LD, 16'd7);
        op(CALL, 16'd50);
        chk("nostack call Q", q_o[0], 16'd7);
        chk("nostack call err", er_o[0], 1'b1);
        chk("nostack full", fu_o[0], 1'b1);
        chk("nostack empty", em_o[0], 1'b1);
`endif
        op(LD, 16'd10);
        op(CALL, 16'd100);
        op(LD | INC, 16'h0);
        call = 1'b1;
        D = 16'd55;
        #2 reset = 1'b1;
        mreset();
        #1;
        chk("async reset Q", q_o[0], 16'h0);
        chk("async reset empty", em_o[0], 1'b1);
        chk("async reset pulses", {ovf_o[0], cf_o[0], er_o[0]}, 3'b0);
        @(negedge clk);
        reset = 1'b0;
        call = 1'b0;
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            logic [5:0] s = r < 8 ? 6'b0 : r < 16 ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            logic [15:0] d = ($urandom_range(0, 3) == 0) ? ev[$urandom_range(0, 5)] : 16'($urandom);
            op(s, d, $urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
